alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; bench and RTL SHALL work at the default.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 req0_op / req1_op  input  2  ALU opcode (addOp, subOp, xorOp, sltOp encodings).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  signed operands A, B.
REQ-008 rsp0_valid / rsp1_valid  output  1  response held for requester n.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester n consumes its response.
REQ-010 rsp0_result / rsp1_result  output  WIDTH  registered ALU result.
REQ-011 rsp0_eq / rsp1_eq  output  1  registered ALU equality flag (A == B).

Function
REQ-012 Handshake: operation n accepted on a rising edge where reqn_valid && reqn_ready; response consumed on an edge where rspn_valid && rspn_ready.
REQ-013 FSM states IDLE, EXEC; IDLE -> EXEC on any acceptance; EXEC -> IDLE unconditionally after one cycle.
REQ-014 reqn_ready SHALL be high only in IDLE, when requester n is the grant winner, and when rspn_valid is low or rspn_ready is high that cycle.
REQ-015 reqn_ready SHALL be combinational from state, valids, pending flags and rspn_ready; reqn_valid SHALL NOT depend on reqn_ready.
REQ-016 Grant: only one eligible requester -> it wins; both eligible -> the one not granted last wins (round-robin); last-grant pointer updates only on acceptance.
REQ-017 On acceptance, op, A, B of the winner and a winner-id bit SHALL be latched into an operand register.
REQ-018 In EXEC, a single shared ALU instance computes from the operand register; at end of EXEC, result and eq SHALL be written into response register of the latched winner and its rspn_valid set.
REQ-019 Latency: accept at edge N -> rspn_valid high from edge N+2; throughput one operation per 2 cycles.
REQ-020 rspn_valid, rspn_result, rspn_eq SHALL hold stable until consumed; rspn_valid clears on consumption unless a new result writes the same cycle (write wins, valid stays high).
REQ-021 A requester with an unconsumed response SHALL NOT be granted; the other requester SHALL still be served (no head-of-line blocking).
REQ-022 Arithmetic: add/sub wrap modulo 2^WIDTH; xor bitwise; slt signed, result 1 or 0 zero-extended to WIDTH.
REQ-023 Ops with X-free operands SHALL produce X-free result and eq.

Reset
REQ-024 On reset: state IDLE, rsp0_valid = rsp1_valid = 0, rspn_result = 0, rspn_eq = 0, last-grant pointer = 1 (requester 0 wins first tie), operand register = 0.
REQ-025 Reset during EXEC SHALL discard the in-flight operation; no rspn_valid SHALL rise from it.
REQ-026 req0_ready = req1_ready = 0 in any cycle where reset is high.

Structure
REQ-027 Opcode encodings (addOp, subOp, xorOp, sltOp) SHALL come from the existing shared ALU header; no local redefinition.
REQ-028 FSM state encodings SHALL be local constants of alu_arbiter.
REQ-029 Exactly one sub-module: the existing alu, instantiated once; no other arithmetic in alu_arbiter.

Verification
REQ-030 Single op: req0 add A=10 B=14 accepted at edge N -> rsp0_valid at N+2, rsp0_result=24, rsp0_eq=0; rsp1_valid stays 0.
REQ-031 Tie after reset: both valid, req0 sub 10-14, req1 xor 0x0F0F0F0F^0xAAAAAAAA, rsp ready high -> req0 first (result -4), req1 next (0xA5A5A5A5), accepted 2 cycles apart.
REQ-032 Round-robin: both valid continuously for 4 acceptances -> grants alternate 0,1,0,1.
REQ-033 Backpressure: rsp0_ready=0, req0 slt -32<14 completes (rsp0_result=1) -> req0_ready stays 0, req1 slt 14<-32 accepted and returns 0; rsp0 held unchanged until rsp0_ready=1.
REQ-034 Eq/slt edges: A=B=-14 slt -> result 0, eq=1; A=-14 B=14 -> eq=0, slt result 1.
REQ-035 Reset pulsed in EXEC cycle -> no rspn_valid afterward, all outputs at reset values, next tie granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU opcode encodings
package alu_arbiter_pkg;

   typedef enum logic [1:0] {
      ADD_OP = 2'd0,
      SUB_OP = 2'd1,
      XOR_OP = 2'd2,
      SLT_OP = 2'd3
   } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU: add, sub, xor, signed set-less-than, equality
module alu
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             eq_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         ADD_OP:  result_o = a_i + b_i;
         SUB_OP:  result_o = a_i - b_i;
         XOR_OP:  result_o = a_i ^ b_i;
         SLT_OP:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         default: result_o = '0;
      endcase
      eq_o = (a_i == b_i);
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one ALU, per-requester response registers
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_eq,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_eq
);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             id_q, id_d;
   logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
   logic             rsp0_eq_q, rsp0_eq_d, rsp1_eq_q, rsp1_eq_d;

   logic             elig0, elig1, win, accept, wr0, wr1;
   logic [WIDTH-1:0] alu_result;
   logic             alu_eq;

   alu #(.WIDTH(WIDTH)) u_alu (
      .op_i     (op_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .result_o (alu_result),
      .eq_o     (alu_eq)
   );

   always_comb begin
      // A requester is eligible only if its response slot is free or being drained this cycle
      elig0      = req0_valid && (!rsp0_valid_q || rsp0_ready);
      elig1      = req1_valid && (!rsp1_valid_q || rsp1_ready);
      win        = (elig0 && elig1) ? ~last_q : elig1;
      req0_ready = !reset && (state_q == IDLE) && elig0 && !win;
      req1_ready = !reset && (state_q == IDLE) && elig1 && win;
      accept     = req0_ready || req1_ready;

      state_d = state_q;
      last_d  = last_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
               last_d  = req1_ready;
               id_d    = req1_ready;
               op_d    = req1_ready ? req1_op : req0_op;
               a_d     = req1_ready ? req1_a  : req0_a;
               b_d     = req1_ready ? req1_b  : req0_b;
            end
         end
         EXEC:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A fresh write beats a same-cycle consume so the new result is never lost
      wr0 = (state_q == EXEC) && !id_q;
      wr1 = (state_q == EXEC) &&  id_q;
      rsp0_valid_d  = wr0 ? 1'b1 : (rsp0_ready ? 1'b0 : rsp0_valid_q);
      rsp1_valid_d  = wr1 ? 1'b1 : (rsp1_ready ? 1'b0 : rsp1_valid_q);
      rsp0_result_d = wr0 ? alu_result : rsp0_result_q;
      rsp1_result_d = wr1 ? alu_result : rsp1_result_q;
      rsp0_eq_d     = wr0 ? alu_eq : rsp0_eq_q;
      rsp1_eq_d     = wr1 ? alu_eq : rsp1_eq_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         last_q        <= 1'b1;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         id_q          <= 1'b0;
         rsp0_valid_q  <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp1_result_q <= '0;
         rsp0_eq_q     <= 1'b0;
         rsp1_eq_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         op_q          <= op_d;
         a_q           <= a_d;
         b_q           <= b_d;
         id_q          <= id_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp1_result_q <= rsp1_result_d;
         rsp0_eq_q     <= rsp0_eq_d;
         rsp1_eq_q     <= rsp1_eq_d;
      end
   end

   assign rsp0_valid  = rsp0_valid_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp0_eq     = rsp0_eq_q;
   assign rsp1_eq     = rsp1_eq_q;

endmodule
